// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin front end that shares one exponential unit among
// N_REQ requesters. It takes one request at a time, starts the unit, waits
// for done (with a timeout) and returns the result to the granted requester.
module exp_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  x_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [17:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 exp_start,
  output logic [15:0]          exp_x,
  input  logic                 exp_done,
  input  logic [1:0]           exp_intpart,
  input  logic [15:0]          exp_fracpart
);

  localparam int unsigned    IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [IW-1:0]  LAST_RST  = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]    idx, idx_nxt;
  logic [IW-1:0]    last, last_nxt;
  logic [IW-1:0]    win_idx, cand;
  logic             win_found;
  logic [7:0]       timer, timer_nxt;
  logic [N_REQ-1:0] gnt_nxt, rsp_valid_nxt;
  logic [17:0]      rsp_data_nxt;
  logic             rsp_err_nxt, busy_nxt, start_nxt;
  logic [15:0]      exp_x_nxt;
  logic             done_ok, tmo;

  // done is only honoured once the start pulse has been seen by the unit
  assign done_ok = exp_done & ~exp_start;
  assign tmo     = (timer == TIMEOUT_C);

  // Round-robin search starting one past the last served requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(last) + 32'd1 + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State and all outputs registered together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= LAST_RST;
      timer     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      exp_start <= 1'b0;
      exp_x     <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      last      <= last_nxt;
      timer     <= timer_nxt;
      gnt       <= gnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      busy      <= busy_nxt;
      exp_start <= start_nxt;
      exp_x     <= exp_x_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = WAIT;
      WAIT:    if (done_ok || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; outputs are computed
  // one cycle early so every port comes straight from a flop
  always_comb begin
    gnt_nxt       = '0;
    rsp_valid_nxt = '0;
    rsp_data_nxt  = '0;
    rsp_err_nxt   = 1'b0;
    start_nxt     = 1'b0;
    exp_x_nxt     = exp_x;
    idx_nxt       = idx;
    last_nxt      = last;
    timer_nxt     = timer;
    busy_nxt      = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (win_found) begin
          idx_nxt          = win_idx;
          gnt_nxt[win_idx] = 1'b1;
          start_nxt        = 1'b1;
          exp_x_nxt        = x_in[{win_idx, 4'b0000} +: 16];
          timer_nxt        = '0;
        end
      end
      WAIT: begin
        if (done_ok) begin
          rsp_valid_nxt[idx] = 1'b1;
          rsp_data_nxt       = {exp_intpart, exp_fracpart};
        end else if (tmo) begin
          rsp_valid_nxt[idx] = 1'b1;
          rsp_err_nxt        = 1'b1;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      RESP: begin
        last_nxt = idx;
      end
      default: begin
      end
    endcase
  end

endmodule
